noc_link_relay: RTL and testbench
=================================

// Module: noc_link_relay
// PURPOSE
//  Credit-based relay buffer on a router-to-router NoC link, downstream of a router output port.
//  - Toward the router: a credit-flow sink with its own flit FIFO.
//  - Toward the next router input: a credit-flow source with its own credit counter.
//  - Breaks long inter-router wires and decouples round-trip credit latency from router buffer depth.
// PARAMETERS
//  FLIT_WIDTH          128  flit payload width
//  DEST_WIDTH          4    destination field width (TDEST+TID)
//  LINK_BUFFER_DEPTH   2    relay FIFO entries (>=2); upstream must be initialised with this many credits
//  DOWNSTREAM_CREDITS  2    initial credits toward the downstream input buffer (= its FLIT_BUFFER_DEPTH, >=1)
// PORTS
//  clk_noc      in   1           NoC clock; only clock
//  rst_noc      in   1           asynchronous, active-high reset
//  data_in      in   FLIT_WIDTH  flit from upstream router
//  dest_in      in   DEST_WIDTH  flit destination
//  is_tail_in   in   1           last flit of packet
//  send_in      in   1           flit valid (one flit per asserted cycle)
//  credit_out   out  1           one-cycle pulse per FIFO entry freed, to upstream
//  data_out     out  FLIT_WIDTH  registered flit to downstream router
//  dest_out     out  DEST_WIDTH  registered destination
//  is_tail_out  out  1           registered tail flag
//  send_out     out  1           registered flit valid
//  credit_in    in   1           one-cycle pulse per downstream buffer entry freed
//  occupancy    out  clog2(LINK_BUFFER_DEPTH+1)  current FIFO fill level
//  err          out  2           sticky: [0] FIFO overflow, [1] credit overflow
// BEHAVIOUR
//  Reset values (async, immediate on rst_noc):
//   - all outputs 0
//   - FIFO empty, FIFO contents discarded
//   - credit counter cnt = DOWNSTREAM_CREDITS
//   - err cleared
//   - A flit in flight at reset assertion is lost; no credit is returned for it.
//  Push: send_in=1 writes {data,dest,tail} at the clock edge if count<DEPTH, or if count==DEPTH with a pop in the same cycle.
//  Overflow: send_in=1 with count==DEPTH and no pop -> flit dropped, err[0] set.
//  Issue rule: pop when FIFO non-empty and cnt>0 (evaluated on registered state).
//   - On pop: output register loads the head flit, send_out=1 next cycle.
//   - Otherwise send_out=0 next cycle and data_out/dest_out/is_tail_out hold their last value.
//  cnt update: decrement on pop, increment on credit_in; both in one cycle -> unchanged.
//   - Width: clog2(DOWNSTREAM_CREDITS+1).
//   - credit_in with cnt==DOWNSTREAM_CREDITS and no pop -> saturates, err[1] set.
//  credit_out: registered copy of pop, asserted the cycle after each pop; one pulse per flit.
//  Latency: send_in in cycle t into an empty FIFO with cnt>0 -> send_out in cycle t+2.
//  Throughput: 1 flit/cycle sustained while cnt>0. Order preserved; the tail flag is never altered.
//  Zero credits: the FIFO fills; upstream stalls by its own credit count. Issue resumes the cycle after credit_in.
//  FIFO pointers wrap modulo LINK_BUFFER_DEPTH; non-power-of-2 depths are supported.
// CONFIGURATION
//  NOC_LINK_CHECK_EN defined:
//   - err flags are generated as described.
//   - Simulation assertions: no send_in while full; no credit_in beyond DOWNSTREAM_CREDITS.
//  NOC_LINK_CHECK_EN undefined:
//   - err tied to 2'b00; no assertions.
//   - Overflowing push is still dropped, and the counter still saturates, so datapath behaviour is identical.
// STRUCTURE
//  noc_link_pkg:
//   - typedef link_flit_t {dest, is_tail, data}, parameterised via localparams FLIT_WIDTH/DEST_WIDTH
//   - function clog2-based width helpers
//   - enum-free; no state machine beyond counters.
//  Sub-module noc_link_fifo:
//   - synchronous, single-clock FIFO of link_flit_t
//   - ports: push, pop, full, empty, count; async active-high clear
//  Top level holds the credit counter, issue logic, output register, credit_out register and checks.
// TESTING
//  1. Reset, then DEPTH=2/CREDITS=2 and 4 back-to-back flits with credit_in returned 3 cycles after each send_out
//     -> flits emerge in order; first send_out at t+2; no err.
//  2. Hold credit_in=0; send 4 flits (2 consumed by credits, 2 buffered)
//     -> occupancy=2, send_out idle; one credit_in pulse -> exactly one flit out the next cycle.
//  3. Same cycle: pop and push with FIFO full
//     -> push accepted, occupancy stays 2, no err[0]; credit_out pulse one cycle later.
//  4. send_in with FIFO full and cnt=0
//     -> flit dropped, err[0]=1 and sticky; with the macro undefined err stays 0.
//  5. credit_in at cnt=DOWNSTREAM_CREDITS with no traffic
//     -> cnt stays 2, err[1]=1.
//  6. Assert rst_noc mid-packet, FIFO holding 2 flits
//     -> outputs 0 immediately; after release occupancy=0, cnt=2, next flit latency t+2.

Source files
------------

// File: rtl/noc_link_pkg.sv
// noc_link_pkg: flit type and width helpers shared by the NoC link relay and its FIFO
package noc_link_pkg;
  localparam int FLIT_WIDTH = 128;
  localparam int DEST_WIDTH = 4;
  typedef struct packed {
    logic [DEST_WIDTH-1:0] dest;
    logic                  is_tail;
    logic [FLIT_WIDTH-1:0] data;
  } link_flit_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int ptr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/noc_link_fifo.sv
// noc_link_fifo: single-clock flit FIFO with async clear; pointers wrap at DEPTH so any depth works
module noc_link_fifo
  import noc_link_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  link_flit_t              din,
  output link_flit_t              dout,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(DEPTH)-1:0] count
);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = ptr_w(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  link_flit_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      count <= do_push && !do_pop ? count + 1'b1 : do_pop && !do_push ? count - 1'b1 : count;
    end
endmodule

// File: rtl/noc_link_relay.sv
// noc_link_relay: credit-flow relay buffer between two NoC routers.
// NOC_LINK_CHECK_EN enables sticky err flags and protocol assertions; otherwise err is 0.
module noc_link_relay
  import noc_link_pkg::*;
#(
  parameter int LINK_BUFFER_DEPTH  = 2,
  parameter int DOWNSTREAM_CREDITS = 2
) (
  input  logic                                clk_noc,
  input  logic                                rst_noc,
  input  logic [FLIT_WIDTH-1:0]               data_in,
  input  logic [DEST_WIDTH-1:0]               dest_in,
  input  logic                                is_tail_in,
  input  logic                                send_in,
  output logic                                credit_out,
  output logic [FLIT_WIDTH-1:0]               data_out,
  output logic [DEST_WIDTH-1:0]               dest_out,
  output logic                                is_tail_out,
  output logic                                send_out,
  input  logic                                credit_in,
  output logic [cnt_w(LINK_BUFFER_DEPTH)-1:0] occupancy,
  output logic [1:0]                          err
);
  localparam int KW = cnt_w(DOWNSTREAM_CREDITS);
  localparam logic [KW-1:0] KMAX = KW'(DOWNSTREAM_CREDITS);
  link_flit_t flit_in, head;
  logic full, empty, pop, push;
  logic [KW-1:0] cnt;
  assign flit_in = {dest_in, is_tail_in, data_in};
  assign pop     = !empty && cnt != '0;
  assign push    = send_in && (!full || pop);
  noc_link_fifo #(.DEPTH(LINK_BUFFER_DEPTH)) u_fifo (
    .clk  (clk_noc),
    .rst  (rst_noc),
    .push (push),
    .pop  (pop),
    .din  (flit_in),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(occupancy)
  );
  // credit counter saturates at KMAX so a stray credit cannot inflate the window
  always_ff @(posedge clk_noc or posedge rst_noc)
    if (rst_noc) begin
      cnt         <= KMAX;
      send_out    <= 1'b0;
      credit_out  <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      cnt        <= pop && !credit_in ? cnt - 1'b1 : credit_in && !pop && cnt != KMAX ? cnt + 1'b1 : cnt;
      send_out   <= pop;
      credit_out <= pop;
      if (pop) {dest_out, is_tail_out, data_out} <= head;
    end
`ifdef NOC_LINK_CHECK_EN
  logic fifo_ovf, credit_ovf;
  assign fifo_ovf   = send_in && full && !pop;
  assign credit_ovf = credit_in && !pop && cnt == KMAX;
  always_ff @(posedge clk_noc or posedge rst_noc)
    if (rst_noc) err <= 2'b00;
    else err <= err | {credit_ovf, fifo_ovf};
  ap_no_fifo_ovf: assert property (@(posedge clk_noc) disable iff (rst_noc) !fifo_ovf);
  ap_no_credit_ovf: assert property (@(posedge clk_noc) disable iff (rst_noc) !credit_ovf);
`else
  assign err = 2'b00;
`endif
endmodule

// File: tb/tb_noc_link_relay.sv
// tb_noc_link_relay: directed scenarios for the NoC link relay with hand-computed expectations
module tb_noc_link_relay;
  logic         clk_noc = 1'b0;
  logic         rst_noc = 1'b1;
  logic [127:0] data_in = '0;
  logic [3:0]   dest_in = '0;
  logic         is_tail_in = 1'b0;
  logic         send_in = 1'b0;
  logic         credit_in = 1'b0;
  logic         credit_out, is_tail_out, send_out;
  logic [127:0] data_out;
  logic [3:0]   dest_out;
  logic [1:0]   occupancy;
  logic [1:0]   err;
  int total = 0;
  int bad = 0;
`ifdef NOC_LINK_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  noc_link_relay dut (
    .clk_noc(clk_noc), .rst_noc(rst_noc), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .occupancy(occupancy), .err(err)
  );
  always #5 clk_noc = ~clk_noc;
  function automatic logic [127:0] fd(input int i);
    return {4{32'hC0DE_0000 | 32'(i)}};
  endfunction
  task automatic drive(input int i);
    send_in = 1'b1;
    data_in = fd(i);
    dest_in = 4'(i);
    is_tail_in = i % 4 == 3;
  endtask
  task automatic idle();
    send_in = 1'b0;
  endtask
  task automatic test_reset();
    rst_noc = 1'b1;
    #3;
    total++;
    if ({send_out, credit_out, is_tail_out, dest_out, data_out, occupancy, err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got send=%b credit=%b data=%h occ=%0d err=%b want all 0", send_out, credit_out, data_out, occupancy, err);
    end
    repeat (2) @(negedge clk_noc);
    rst_noc = 1'b0;
    @(negedge clk_noc);
    total++;
    if (dut.cnt !== 2'd2 || occupancy !== 2'd0) begin
      bad++;
      $display("FAIL reset_state got cnt=%0d occ=%0d want cnt=2 occ=0", dut.cnt, occupancy);
    end
  endtask
  task automatic test_back_to_back();
    int got = 0;
    int pulses = 0;
    logic [15:0] pend = '0;
    for (int c = 0; c < 16; c++) begin
      if (send_out) begin
        total++;
        if (got > 3 || data_out !== fd(got) || dest_out !== 4'(got) || is_tail_out !== (got == 3)) begin
          bad++;
          $display("FAIL b2b_flit%0d got data=%h dest=%0d tail=%b want data=%h dest=%0d", got, data_out, dest_out, is_tail_out, fd(got), got);
        end
        if (got == 0) begin
          total++;
          if (c != 2) begin
            bad++;
            $display("FAIL b2b_latency got cycle %0d want cycle 2", c);
          end
        end
        if (c + 3 < 16) pend[c+3] = 1'b1;
        got++;
      end
      if (credit_out) pulses++;
      if (c < 4) drive(c);
      else idle();
      credit_in = pend[c];
      @(negedge clk_noc);
    end
    total++;
    if (got != 4 || pulses != 4) begin
      bad++;
      $display("FAIL b2b_count got flits=%0d credits=%0d want 4 and 4", got, pulses);
    end
    total++;
    if (dut.cnt !== 2'd2 || occupancy !== 2'd0 || err !== 2'b00) begin
      bad++;
      $display("FAIL b2b_end got cnt=%0d occ=%0d err=%b want 2 0 00", dut.cnt, occupancy, err);
    end
  endtask
  task automatic test_zero_credit();
    credit_in = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(10 + c);
      else idle();
      @(negedge clk_noc);
    end
    total++;
    if (occupancy !== 2'd2 || send_out !== 1'b0 || dut.cnt !== 2'd0) begin
      bad++;
      $display("FAIL zc_stall got occ=%0d send=%b cnt=%0d want 2 0 0", occupancy, send_out, dut.cnt);
    end
    credit_in = 1'b1;
    @(negedge clk_noc);
    credit_in = 1'b0;
    total++;
    if (send_out !== 1'b0) begin
      bad++;
      $display("FAIL zc_early got send=%b want 0", send_out);
    end
    @(negedge clk_noc);
    total++;
    if (send_out !== 1'b1 || data_out !== fd(12)) begin
      bad++;
      $display("FAIL zc_resume got send=%b data=%h want 1 %h", send_out, data_out, fd(12));
    end
    @(negedge clk_noc);
    total++;
    if (send_out !== 1'b0 || occupancy !== 2'd1) begin
      bad++;
      $display("FAIL zc_single got send=%b occ=%0d want 0 1", send_out, occupancy);
    end
  endtask
  task automatic test_full_pop_push();
    drive(14);
    @(negedge clk_noc);
    idle();
    total++;
    if (occupancy !== 2'd2) begin
      bad++;
      $display("FAIL fpp_fill got occ=%0d want 2", occupancy);
    end
    credit_in = 1'b1;
    @(negedge clk_noc);
    credit_in = 1'b0;
    drive(15);
    @(negedge clk_noc);
    idle();
    total++;
    if (occupancy !== 2'd2 || err[0] !== 1'b0 || credit_out !== 1'b1 || send_out !== 1'b1 || data_out !== fd(13)) begin
      bad++;
      $display("FAIL fpp_same_cycle got occ=%0d err0=%b credit=%b send=%b data=%h want 2 0 1 1 %h", occupancy, err[0], credit_out, send_out, data_out, fd(13));
    end
    @(negedge clk_noc);
    total++;
    if (credit_out !== 1'b0) begin
      bad++;
      $display("FAIL fpp_pulse got credit=%b want 0", credit_out);
    end
  endtask
  task automatic test_overflow();
    drive(16);
    @(negedge clk_noc);
    idle();
    total++;
    if (occupancy !== 2'd2 || err[0] !== EXP_ERR) begin
      bad++;
      $display("FAIL ovf_drop got occ=%0d err0=%b want 2 %b", occupancy, err[0], EXP_ERR);
    end
    @(negedge clk_noc);
    total++;
    if (err[0] !== EXP_ERR) begin
      bad++;
      $display("FAIL ovf_sticky got err0=%b want %b", err[0], EXP_ERR);
    end
    credit_in = 1'b1;
    repeat (2) @(negedge clk_noc);
    credit_in = 1'b0;
    total++;
    if (send_out !== 1'b1 || data_out !== fd(14)) begin
      bad++;
      $display("FAIL ovf_drain0 got send=%b data=%h want 1 %h", send_out, data_out, fd(14));
    end
    @(negedge clk_noc);
    total++;
    if (send_out !== 1'b1 || data_out !== fd(15)) begin
      bad++;
      $display("FAIL ovf_drain1 got send=%b data=%h want 1 %h", send_out, data_out, fd(15));
    end
    @(negedge clk_noc);
    total++;
    if (send_out !== 1'b0 || occupancy !== 2'd0) begin
      bad++;
      $display("FAIL ovf_dropped got send=%b occ=%0d want 0 0", send_out, occupancy);
    end
  endtask
  task automatic test_credit_overflow();
    credit_in = 1'b1;
    repeat (2) @(negedge clk_noc);
    total++;
    if (dut.cnt !== 2'd2 || err[1] !== 1'b0) begin
      bad++;
      $display("FAIL cov_refill got cnt=%0d err1=%b want 2 0", dut.cnt, err[1]);
    end
    @(negedge clk_noc);
    credit_in = 1'b0;
    total++;
    if (dut.cnt !== 2'd2 || err[1] !== EXP_ERR) begin
      bad++;
      $display("FAIL cov_saturate got cnt=%0d err1=%b want 2 %b", dut.cnt, err[1], EXP_ERR);
    end
  endtask
  task automatic test_reset_mid_packet();
    for (int c = 0; c < 4; c++) begin
      drive(20 + c);
      @(negedge clk_noc);
    end
    drive(24);
    total++;
    if (occupancy !== 2'd2 || data_out !== fd(21)) begin
      bad++;
      $display("FAIL rst_pre got occ=%0d data=%h want 2 %h", occupancy, data_out, fd(21));
    end
    #2 rst_noc = 1'b1;
    #1;
    total++;
    if ({send_out, credit_out, is_tail_out, dest_out, data_out, occupancy, err} !== '0) begin
      bad++;
      $display("FAIL rst_async got send=%b data=%h occ=%0d err=%b want all 0", send_out, data_out, occupancy, err);
    end
    idle();
    @(negedge clk_noc);
    rst_noc = 1'b0;
    total++;
    if (occupancy !== 2'd0 || dut.cnt !== 2'd2) begin
      bad++;
      $display("FAIL rst_release got occ=%0d cnt=%0d want 0 2", occupancy, dut.cnt);
    end
    drive(25);
    @(negedge clk_noc);
    idle();
    total++;
    if (send_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_lat1 got send=%b want 0", send_out);
    end
    @(negedge clk_noc);
    total++;
    if (send_out !== 1'b1 || data_out !== fd(25) || dest_out !== 4'd9 || is_tail_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_lat2 got send=%b data=%h dest=%0d want 1 %h 9", send_out, data_out, dest_out, fd(25));
    end
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_zero_credit();
    test_full_pop_push();
    test_overflow();
    test_credit_overflow();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
